// File: rtl/uart_reg_pkg.sv
// Shared constants for the UART register-bank controller: address map,
// register select indices, CTRL/ISR bit positions and FSM state encodings.
package uart_reg_pkg;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BAUD_W   = 16;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CTRL_W   = 5;
    localparam int unsigned ISR_W    = 3;
    localparam int unsigned NUM_REGS = 7;

    localparam logic [BAUD_W-1:0] BAUD_RST = 16'd27;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 12'h000;
    localparam logic [ADDR_W-1:0] ADDR_BAUD   = 12'h004;
    localparam logic [ADDR_W-1:0] ADDR_TXDATA = 12'h008;
    localparam logic [ADDR_W-1:0] ADDR_RXDATA = 12'h00C;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 12'h010;
    localparam logic [ADDR_W-1:0] ADDR_IER    = 12'h014;
    localparam logic [ADDR_W-1:0] ADDR_ISR    = 12'h018;

    // One-hot register select indices
    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_BAUD   = 1;
    localparam int unsigned REG_TXDATA = 2;
    localparam int unsigned REG_RXDATA = 3;
    localparam int unsigned REG_STATUS = 4;
    localparam int unsigned REG_IER    = 5;
    localparam int unsigned REG_ISR    = 6;

    // Registers that accept each access direction (bit i = REG index i)
    localparam logic [NUM_REGS-1:0] WR_LEGAL = 7'b110_0111;
    localparam logic [NUM_REGS-1:0] RD_LEGAL = 7'b111_1011;

    localparam int unsigned CTRL_TX_EN   = 0;
    localparam int unsigned CTRL_RX_EN   = 1;
    localparam int unsigned CTRL_PAR_EN  = 2;
    localparam int unsigned CTRL_PAR_ODD = 3;
    localparam int unsigned CTRL_STOP2   = 4;

    localparam int unsigned ISR_TX_EMPTY    = 0;
    localparam int unsigned ISR_RX_NONEMPTY = 1;
    localparam int unsigned ISR_OVR         = 2;

    typedef logic [1:0] reg_state_e;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WACK = 2'd1;
    localparam logic [1:0] ST_RACK = 2'd2;

endpackage

// File: rtl/uart_reg_if.sv
// Register-side bus between the APB bridge (master) and the UART register bank (slave).
interface uart_reg_if;
    import uart_reg_pkg::*;

    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;
    logic [ADDR_W-1:0] raddr;
    logic              rd_en;
    logic [DATA_W-1:0] rdata;
    logic              wack;
    logic              rack;
    logic              waddrerr;
    logic              raddrerr;

    modport master (
        output waddr, wdata, wr_en, raddr, rd_en,
        input  rdata, wack, rack, waddrerr, raddrerr
    );

    modport slave (
        input  waddr, wdata, wr_en, raddr, rd_en,
        output rdata, wack, rack, waddrerr, raddrerr
    );

endinterface

// File: rtl/uart_reg_decode.sv
// Address decoder: one-hot register select for the given access direction,
// error when the address is unmapped, misaligned or illegal for that direction.
module uart_reg_decode
    import uart_reg_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    input  logic                is_wr,
    output logic [NUM_REGS-1:0] sel_c,
    output logic                err_c
);

    logic [NUM_REGS-1:0] hit_c;

    // Misaligned addresses never match a word-aligned map entry
    always_comb begin
        hit_c = '0;
        case (addr)
            ADDR_CTRL:   hit_c[REG_CTRL]   = 1'b1;
            ADDR_BAUD:   hit_c[REG_BAUD]   = 1'b1;
            ADDR_TXDATA: hit_c[REG_TXDATA] = 1'b1;
            ADDR_RXDATA: hit_c[REG_RXDATA] = 1'b1;
            ADDR_STATUS: hit_c[REG_STATUS] = 1'b1;
            ADDR_IER:    hit_c[REG_IER]    = 1'b1;
            ADDR_ISR:    hit_c[REG_ISR]    = 1'b1;
            default:     hit_c = '0;
        endcase
        sel_c = hit_c & (is_wr ? WR_LEGAL : RD_LEGAL);
        err_c = ~|sel_c;
    end

endmodule

// File: rtl/uart_reg_ctrl.sv
// UART register bank behind the APB bridge: one access per strobe run,
// single-cycle acks, configuration registers, FIFO push/pop and interrupt.
module uart_reg_ctrl
    import uart_reg_pkg::*;
#(
    parameter logic [BAUD_W-1:0] BAUD_RST = uart_reg_pkg::BAUD_RST
) (
    input  logic              pclk,
    input  logic              prst_n,
    uart_reg_if.slave         bus,
    output logic              tx_en,
    output logic              rx_en,
    output logic              par_en,
    output logic              par_odd,
    output logic              stop2,
    output logic [BAUD_W-1:0] baud_div,
    output logic              tx_push,
    output logic [BYTE_W-1:0] tx_data,
    output logic              rx_pop,
    input  logic              tx_full,
    input  logic              tx_empty,
    input  logic              rx_full,
    input  logic              rx_empty,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_ovr,
    output logic              irq
);

    reg_state_e        state_q, state_d;
    logic              wr_en_q, rd_en_q;
    logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [ISR_W-1:0]  ier_q, ier_d;
    logic              ovr_q, ovr_d;
    logic              wack_q, wack_d, rack_q, rack_d;
    logic              waddrerr_q, waddrerr_d, raddrerr_q, raddrerr_d;
    logic              tx_push_q, tx_push_d, rx_pop_q, rx_pop_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic [NUM_REGS-1:0] wsel_c, rsel_c;
    logic                wdec_err_c, rdec_err_c;
    logic                wr_req_c, rd_req_c, wr_err_c, rd_err_c;
    logic [ISR_W-1:0]    isr_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic                unused_wdata_c;

    uart_reg_decode u_wdec (.addr(bus.waddr), .is_wr(1'b1), .sel_c(wsel_c), .err_c(wdec_err_c));
    uart_reg_decode u_rdec (.addr(bus.raddr), .is_wr(1'b0), .sel_c(rsel_c), .err_c(rdec_err_c));

    // A request is a fresh strobe edge or one deferred while the FSM was busy
    assign wr_req_c = (bus.wr_en & ~wr_en_q) | wr_pend_q;
    assign rd_req_c = (bus.rd_en & ~rd_en_q) | rd_pend_q;
    assign wr_err_c = wdec_err_c | (wsel_c[REG_TXDATA] & tx_full);
    assign rd_err_c = rdec_err_c | (rsel_c[REG_RXDATA] & rx_empty);
    assign isr_c    = {ovr_q, ~rx_empty, tx_empty};
    assign unused_wdata_c = ^bus.wdata[DATA_W-1:BAUD_W];

    always_comb begin
        rd_word_c = '0;
        if (rsel_c[REG_CTRL])   rd_word_c = DATA_W'(ctrl_q);
        if (rsel_c[REG_BAUD])   rd_word_c = DATA_W'(baud_q);
        if (rsel_c[REG_RXDATA]) rd_word_c = DATA_W'(rx_byte);
        if (rsel_c[REG_STATUS]) rd_word_c = DATA_W'({rx_full, rx_empty, tx_full, tx_empty});
        if (rsel_c[REG_IER])    rd_word_c = DATA_W'(ier_q);
        if (rsel_c[REG_ISR])    rd_word_c = DATA_W'(isr_c);
    end

    // Next-state, register-update and output logic; writes win over reads
    always_comb begin
        state_d    = state_q;
        wr_pend_d  = wr_req_c;
        rd_pend_d  = rd_req_c;
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        ier_d      = ier_q;
        ovr_d      = ovr_q | rx_ovr;
        wack_d     = 1'b0;
        rack_d     = 1'b0;
        waddrerr_d = 1'b0;
        raddrerr_d = 1'b0;
        tx_push_d  = 1'b0;
        tx_data_d  = tx_data_q;
        rx_pop_d   = 1'b0;
        rdata_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req_c) begin
                    state_d    = ST_WACK;
                    wr_pend_d  = 1'b0;
                    wack_d     = 1'b1;
                    waddrerr_d = wr_err_c;
                    if (!wr_err_c) begin
                        if (wsel_c[REG_CTRL]) ctrl_d = bus.wdata[CTRL_W-1:0];
                        if (wsel_c[REG_BAUD]) baud_d = bus.wdata[BAUD_W-1:0];
                        if (wsel_c[REG_IER])  ier_d  = bus.wdata[ISR_W-1:0];
                        if (wsel_c[REG_ISR] && bus.wdata[ISR_OVR]) ovr_d = rx_ovr;
                        if (wsel_c[REG_TXDATA]) begin
                            tx_push_d = 1'b1;
                            tx_data_d = bus.wdata[BYTE_W-1:0];
                        end
                    end
                end else if (rd_req_c) begin
                    state_d    = ST_RACK;
                    rd_pend_d  = 1'b0;
                    rack_d     = 1'b1;
                    raddrerr_d = rd_err_c;
                    if (!rd_err_c) begin
                        rdata_d  = rd_word_c;
                        rx_pop_d = rsel_c[REG_RXDATA];
                    end
                end
            end
            ST_WACK, ST_RACK: state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
        irq_d = |({ovr_d, ~rx_empty, tx_empty} & ier_d);
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            ctrl_q     <= '0;
            baud_q     <= BAUD_RST;
            ier_q      <= '0;
            ovr_q      <= 1'b0;
            wack_q     <= 1'b0;
            rack_q     <= 1'b0;
            waddrerr_q <= 1'b0;
            raddrerr_q <= 1'b0;
            tx_push_q  <= 1'b0;
            tx_data_q  <= '0;
            rx_pop_q   <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= bus.wr_en;
            rd_en_q    <= bus.rd_en;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            ier_q      <= ier_d;
            ovr_q      <= ovr_d;
            wack_q     <= wack_d;
            rack_q     <= rack_d;
            waddrerr_q <= waddrerr_d;
            raddrerr_q <= raddrerr_d;
            tx_push_q  <= tx_push_d;
            tx_data_q  <= tx_data_d;
            rx_pop_q   <= rx_pop_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.wack     = wack_q;
    assign bus.rack     = rack_q;
    assign bus.waddrerr = waddrerr_q;
    assign bus.raddrerr = raddrerr_q;
    assign bus.rdata    = rdata_q;
    assign tx_en    = ctrl_q[CTRL_TX_EN];
    assign rx_en    = ctrl_q[CTRL_RX_EN];
    assign par_en   = ctrl_q[CTRL_PAR_EN];
    assign par_odd  = ctrl_q[CTRL_PAR_ODD];
    assign stop2    = ctrl_q[CTRL_STOP2];
    assign baud_div = baud_q;
    assign tx_push  = tx_push_q;
    assign tx_data  = tx_data_q;
    assign rx_pop   = rx_pop_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Bench for uart_reg_ctrl: directed vector table, hand-written multi-cycle
// sequences and random accesses checked against a register-level model.
module tb_uart_reg_ctrl;

    logic        pclk;
    logic        prst_n;
    logic        tx_en, rx_en, par_en, par_odd, stop2;
    logic [15:0] baud_div;
    logic        tx_push;
    logic [7:0]  tx_data;
    logic        rx_pop;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]  rx_byte;
    logic        rx_ovr;
    logic        irq;

    uart_reg_if bus ();

    uart_reg_ctrl dut (
        .pclk(pclk), .prst_n(prst_n), .bus(bus),
        .tx_en(tx_en), .rx_en(rx_en), .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
        .baud_div(baud_div), .tx_push(tx_push), .tx_data(tx_data), .rx_pop(rx_pop),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
        .rx_byte(rx_byte), .rx_ovr(rx_ovr), .irq(irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Register-level model of the programmable state
    logic [4:0]  m_ctrl;
    logic [15:0] m_baud;
    logic [2:0]  m_ier;
    bit          m_ovr;

    typedef struct {
        bit          is_wr;
        logic [11:0] addr;
        logic [31:0] data;
        int          hold;
        bit          tx_full;
        bit          rx_empty;
        logic [7:0]  rx_byte;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_wr_err(input logic [11:0] a, input logic txf);
        return !(a[1:0] == 2'b00 && a <= 12'h018 && a != 12'h00C && a != 12'h010 &&
                 !(a == 12'h008 && txf));
    endfunction

    function automatic bit m_rd_err(input logic [11:0] a, input logic rxe);
        return !(a[1:0] == 2'b00 && a <= 12'h018 && a != 12'h008 && !(a == 12'h00C && rxe));
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h000: return 32'(m_ctrl);
            12'h004: return 32'(m_baud);
            12'h00C: return 32'(rx_byte);
            12'h010: return 32'({rx_full, rx_empty, tx_full, tx_empty});
            12'h014: return 32'(m_ier);
            12'h018: return 32'({m_ovr, ~rx_empty, tx_empty});
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] d);
        if (m_wr_err(a, tx_full)) return;
        case (a)
            12'h000: m_ctrl = d[4:0];
            12'h004: m_baud = d[15:0];
            12'h014: m_ier  = d[2:0];
            12'h018: if (d[2]) m_ovr = 1'b0;
            default: ;
        endcase
    endfunction

    function automatic void m_reset();
        m_ctrl = '0;
        m_baud = 16'd27;
        m_ier  = '0;
        m_ovr  = 1'b0;
    endfunction

    task automatic check_cfg();
        check("ctrl_bits", 32'({stop2, par_odd, par_en, rx_en, tx_en}), 32'(m_ctrl));
        check("baud_div", 32'(baud_div), 32'(m_baud));
        check("irq", 32'(irq), 32'(|({m_ovr, ~rx_empty, tx_empty} & m_ier)));
    endtask

    // Called at a negedge with the DUT idle; wr_en held for 'hold' cycles
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input int hold,
                            input bit exp_err, input bit ovr);
        bit exp_push;
        exp_push    = (a == 12'h008) && !exp_err;
        bus.waddr   = a;
        bus.wdata   = d;
        bus.wr_en   = 1'b1;
        rx_ovr      = ovr;
        @(negedge pclk);
        rx_ovr = 1'b0;
        check("wack", 32'(bus.wack), 32'd1);
        check("waddrerr", 32'(bus.waddrerr), 32'(exp_err));
        check("rack_in_write", 32'(bus.rack), 32'd0);
        check("tx_push", 32'(tx_push), 32'(exp_push));
        if (exp_push) check("tx_data", 32'(tx_data), 32'(d[7:0]));
        for (int i = 1; i < hold; i++) begin
            @(negedge pclk);
            check("wack_once", 32'(bus.wack), 32'd0);
            check("tx_push_once", 32'(tx_push), 32'd0);
        end
        bus.wr_en = 1'b0;
        @(negedge pclk);
        check("wack_end", 32'(bus.wack), 32'd0);
        check("tx_push_end", 32'(tx_push), 32'd0);
    endtask

    task automatic do_read(input logic [11:0] a, input bit exp_err, input logic [31:0] exp_data);
        bit exp_pop;
        exp_pop   = (a == 12'h00C) && !exp_err;
        bus.raddr = a;
        bus.rd_en = 1'b1;
        @(negedge pclk);
        check("rack", 32'(bus.rack), 32'd1);
        check("raddrerr", 32'(bus.raddrerr), 32'(exp_err));
        check("rdata", bus.rdata, exp_data);
        check("rx_pop", 32'(rx_pop), 32'(exp_pop));
        check("wack_in_read", 32'(bus.wack), 32'd0);
        bus.rd_en = 1'b0;
        @(negedge pclk);
        check("rack_end", 32'(bus.rack), 32'd0);
        check("rdata_zero", bus.rdata, 32'd0);
        check("rx_pop_end", 32'(rx_pop), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 12'h004, 32'h0000_1234, 1, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,         1, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0000_1234};
        vecs[2]  = '{1'b1, 12'h008, 32'h0000_00A5, 3, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 12'h008, 32'h0000_005A, 1, 1'b1, 1'b1, 8'h00, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 12'h01C, 32'h0,         1, 1'b0, 1'b1, 8'h00, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 12'h006, 32'h0000_FFFF, 1, 1'b0, 1'b1, 8'h00, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 12'h00C, 32'h0,         1, 1'b0, 1'b0, 8'h3C, 1'b0, 32'h0000_003C};
        vecs[7]  = '{1'b0, 12'h00C, 32'h0,         1, 1'b0, 1'b1, 8'h3C, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 2, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 12'h000, 32'h0,         1, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0000_001F};
        vecs[10] = '{1'b0, 12'h010, 32'h0,         1, 1'b1, 1'b1, 8'h00, 1'b0, 32'h0000_0006};
        vecs[11] = '{1'b1, 12'h010, 32'h0000_0001, 1, 1'b0, 1'b1, 8'h00, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 12'h00C, 32'h0000_0001, 1, 1'b0, 1'b1, 8'h00, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 12'h008, 32'h0,         1, 1'b0, 1'b1, 8'h00, 1'b1, 32'h0};
        vecs[14] = '{1'b0, 12'h018, 32'h0,         1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0000_0002};
        vecs[15] = '{1'b1, 12'h014, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 12'h014, 32'h0,         1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0000_0007};
        vecs[17] = '{1'b0, 12'h002, 32'h0,         1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
        vecs[18] = '{1'b1, 12'h018, 32'h0000_0004, 1, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0};

        prst_n    = 1'b0;
        bus.waddr = '0; bus.wdata = '0; bus.wr_en = 1'b0;
        bus.raddr = '0; bus.rd_en = 1'b0;
        tx_full = 1'b0; tx_empty = 1'b0; rx_full = 1'b0; rx_empty = 1'b1;
        rx_byte = '0; rx_ovr = 1'b0;
        m_reset();

        // Reset state
        repeat (2) @(negedge pclk);
        check("rst_wack", 32'(bus.wack), 32'd0);
        check("rst_rack", 32'(bus.rack), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_errs", 32'({bus.waddrerr, bus.raddrerr}), 32'd0);
        check("rst_push_pop", 32'({tx_push, rx_pop}), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_baud", 32'(baud_div), 32'd27);
        check_cfg();
        prst_n = 1'b1;
        @(negedge pclk);

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            tx_full  = vecs[i].tx_full;
            rx_empty = vecs[i].rx_empty;
            rx_byte  = vecs[i].rx_byte;
            tx_empty = 1'b0;
            rx_full  = 1'b0;
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].exp_err, 1'b0);
                m_write(vecs[i].addr, vecs[i].data);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp_err, vecs[i].exp_rdata);
            end
            check_cfg();
        end

        // Interrupt: sticky overrun, set beats a simultaneous W1C
        rx_empty = 1'b1; tx_empty = 1'b0;
        do_write(12'h014, 32'h4, 1, 1'b0, 1'b0);
        m_write(12'h014, 32'h4);
        check("irq_before_ovr", 32'(irq), 32'd0);
        rx_ovr = 1'b1;
        @(negedge pclk);
        rx_ovr = 1'b0;
        m_ovr  = 1'b1;
        check("irq_after_ovr", 32'(irq), 32'd1);
        do_write(12'h018, 32'h4, 1, 1'b0, 1'b1);
        m_write(12'h018, 32'h4);
        m_ovr = 1'b1;
        check("irq_set_wins", 32'(irq), 32'd1);
        do_write(12'h018, 32'h4, 1, 1'b0, 1'b0);
        m_write(12'h018, 32'h4);
        check("irq_cleared", 32'(irq), 32'd0);
        check_cfg();

        // Simultaneous write and read starts: write first, read follows
        bus.waddr = 12'h000; bus.wdata = 32'h0A; bus.wr_en = 1'b1;
        bus.raddr = 12'h000; bus.rd_en = 1'b1;
        @(negedge pclk);
        check("simul_wack", 32'(bus.wack), 32'd1);
        check("simul_no_rack", 32'(bus.rack), 32'd0);
        bus.wr_en = 1'b0;
        m_write(12'h000, 32'h0A);
        @(negedge pclk);
        check("simul_gap", 32'({bus.wack, bus.rack}), 32'd0);
        @(negedge pclk);
        check("simul_rack", 32'(bus.rack), 32'd1);
        check("simul_rdata", bus.rdata, 32'h0A);
        check("simul_raddrerr", 32'(bus.raddrerr), 32'd0);
        bus.rd_en = 1'b0;
        @(negedge pclk);
        check("simul_rack_end", 32'(bus.rack), 32'd0);
        check("simul_rdata_zero", bus.rdata, 32'd0);

        // Reset during the ack cycle of a TX push, strobe still high afterwards
        tx_full = 1'b0;
        bus.waddr = 12'h008; bus.wdata = 32'h77; bus.wr_en = 1'b1;
        @(posedge pclk);
        #2 prst_n = 1'b0;
        #1;
        m_reset();
        check("rstmid_wack", 32'(bus.wack), 32'd0);
        check("rstmid_tx_push", 32'(tx_push), 32'd0);
        check("rstmid_baud", 32'(baud_div), 32'd27);
        check("rstmid_ctrl", 32'({stop2, par_odd, par_en, rx_en, tx_en}), 32'd0);
        @(negedge pclk);
        prst_n = 1'b1;
        @(negedge pclk);
        check("rstmid_new_wack", 32'(bus.wack), 32'd1);
        check("rstmid_new_push", 32'(tx_push), 32'd1);
        check("rstmid_new_data", 32'(tx_data), 32'h77);
        bus.wr_en = 1'b0;
        @(negedge pclk);
        check("rstmid_wack_end", 32'(bus.wack), 32'd0);
        check_cfg();

        // Random accesses against the model
        for (int it = 0; it < 80; it++) begin
            logic [11:0] a;
            logic [31:0] d;
            bit          e;
            int          k;
            tx_full  = 1'($urandom);
            tx_empty = 1'($urandom);
            rx_full  = 1'($urandom);
            rx_empty = 1'($urandom);
            rx_byte  = 8'($urandom);
            k = int'($urandom_range(0, 9));
            if (k < 7)       a = 12'(k * 4);
            else if (k == 7) a = 12'h01C;
            else if (k == 8) a = 12'h006;
            else             a = 12'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                rx_ovr = 1'b1;
                @(negedge pclk);
                rx_ovr = 1'b0;
                m_ovr  = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                e = m_wr_err(a, tx_full);
                do_write(a, d, int'($urandom_range(1, 3)), e, 1'b0);
                m_write(a, d);
            end else begin
                e = m_rd_err(a, rx_empty);
                do_read(a, e, e ? 32'h0 : m_read(a));
            end
            check_cfg();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_reg_ctrl.md
# uart_reg_ctrl

Register-bank controller for the UART, sitting directly behind the APB bridge's register-side interface. It turns the bridge's level-style `wr_en`/`rd_en` strobes into exactly one register access per APB transfer and returns single-cycle `wack`/`rack`, read data and decode errors. It also holds the UART configuration, sequences TX-FIFO push and RX-FIFO pop, and generates the interrupt line.

## Interface
- `BAUD_RST`, 16'd27: reset value of `baud_div`.
- `pclk` in 1: clock; all state on rising edge.
- `prst_n` in 1: asynchronous, active-low reset.
- `waddr` in 12: write byte address from bridge.
- `wdata` in 32: write data from bridge.
- `wr_en` in 1: write strobe from bridge; may stay high several cycles per transfer.
- `raddr` in 12: read byte address from bridge.
- `rd_en` in 1: read strobe from bridge; high until `rack`.
- `rdata` out 32: read data, valid while `rack`=1, else 0.
- `wack` out 1: one-cycle write acknowledge.
- `rack` out 1: one-cycle read acknowledge.
- `waddrerr` out 1: write error, valid only with `wack`.
- `raddrerr` out 1: read error, valid only with `rack`.
- `tx_en` out 1: CTRL[0].
- `rx_en` out 1: CTRL[1].
- `par_en` out 1: CTRL[2].
- `par_odd` out 1: CTRL[3].
- `stop2` out 1: CTRL[4].
- `baud_div` out 16: BAUD[15:0].
- `tx_push` out 1: one-cycle push of `tx_data` into the TX FIFO.
- `tx_data` out 8: byte to push.
- `rx_pop` out 1: one-cycle pop of the RX FIFO.
- `tx_full` in 1: TX FIFO status.
- `tx_empty` in 1: TX FIFO status.
- `rx_full` in 1: RX FIFO status.
- `rx_empty` in 1: RX FIFO status.
- `rx_byte` in 8: head of the RX FIFO.
- `rx_ovr` in 1: one-cycle overrun pulse from the receiver.
- `irq` out 1: level interrupt, equal to |(ISR & IER).

## Operation
- Register map (byte address, word-aligned):
  - 0x000 CTRL: RW, bits [4:0].
  - 0x004 BAUD: RW, bits [15:0].
  - 0x008 TXDATA: WO; a write pushes `wdata[7:0]`.
  - 0x00C RXDATA: RO; a read returns the head byte and pops it.
  - 0x010 STATUS: RO; bits {rx_full, rx_empty, tx_full, tx_empty} in [3:0].
  - 0x014 IER: RW, bits [2:0].
  - 0x018 ISR: bits [2:0] = {ovr, rx_nonempty, tx_empty}. Bits 0 and 1 are live status. Bit 2 is sticky, set by `rx_ovr`, cleared by writing 1.
- Start detection:
  - `wr_start` = `wr_en` & ~`wr_en_q`.
  - `rd_start` = `rd_en` & ~`rd_en_q`.
  - Further high cycles of the same strobe run are ignored, so each APB transfer produces exactly one access.
- Write errors (no state change, `waddrerr`=1):
  - unmapped address or `waddr[1:0]`≠0;
  - STATUS or RXDATA;
  - TXDATA while `tx_full`=1 (no push).
- Read errors (`rdata`=0, `raddrerr`=1):
  - unmapped address or misaligned;
  - TXDATA;
  - RXDATA while `rx_empty`=1 (no pop).
- Unused register bits read 0; writes to them are ignored.
- State machine:
  - IDLE → WACK on `wr_start`.
  - IDLE → RACK on `rd_start`.
  - WACK → IDLE.
  - RACK → IDLE.
- Simultaneous `wr_start` and `rd_start`: write first. The read is held pending and taken from IDLE on the next cycle, regardless of `rd_en_q`.
- ISR.ovr: a set from `rx_ovr` and a W1C in the same cycle leave the bit set.

## Timing
- Write:
  - register update in the `wr_start` cycle (committed at its end);
  - `wack`, `waddrerr` and `tx_push` high for exactly the next cycle.
- Read:
  - `rdata` and `raddrerr` captured from `raddr` in the `rd_start` cycle;
  - `rack` and `rx_pop` high for exactly the next cycle;
  - `rdata` returns to 0 the cycle after that.
- `wack` and `rack` are never high in the same cycle.
- Latency from strobe start to ack: 1 cycle.
- The bridge guarantees at least one low cycle of `wr_en` between transfers.
- Reset values:
  - all outputs 0, except `baud_div`=`BAUD_RST`;
  - `irq`=0 (IER resets to 0);
  - ISR.ovr=0;
  - FSM=IDLE;
  - edge registers `wr_en_q`/`rd_en_q`=0.
- Reset mid-access: the access is dropped, no ack is issued, and `tx_push`/`rx_pop` are deasserted immediately.
  - If the strobe is still high after reset release, it is treated as a new start.

## Structure
- Package `uart_reg_pkg`:
  - address localparams;
  - CTRL/ISR bit-index localparams;
  - FSM state enum `reg_state_e`;
  - `BAUD_RST` default.
- One combinational sub-module, `uart_reg_decode`: address + direction in, register select one-hot and error flag out.
- FSM, registers and read mux stay in the top module.

## Test plan
- Reset: all outputs 0, `baud_div`=27.
  - Write BAUD=0x1234 → `wack` for 1 cycle, `waddrerr`=0.
  - Read BAUD → `rack`, `rdata`=0x0000_1234.
- Bridge-style held `wr_en` for 3 cycles writing TXDATA=0xA5 with `tx_full`=0 → exactly one `tx_push`, with `tx_data`=0xA5, and one `wack`.
- Write TXDATA with `tx_full`=1 → `wack`+`waddrerr`, no `tx_push`.
  - Read 0x01C → `rack`+`raddrerr`, `rdata`=0.
  - Write 0x006 → `waddrerr`.
- RX path:
  - `rx_empty`=0, `rx_byte`=0x3C, read RXDATA → `rdata`=0x3C, one `rx_pop`.
  - With `rx_empty`=1 → `raddrerr`, no pop.
- Interrupt:
  - IER=0x4, pulse `rx_ovr` → `irq`=1.
  - Write ISR=0x4 in the same cycle as a new `rx_ovr` pulse → `irq` stays 1.
  - Write ISR=0x4 again → `irq`=0.
- Assert `prst_n`=0 in the WACK cycle → `wack`=0 immediately, CTRL/BAUD at reset values.
  - After release, `wr_en` still high → one new write and `wack` one cycle later.
